// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared APU types and constants for the core-side APU arbiter and its tag FIFO.
package cv32e40p_apu_core_pkg;

    localparam int APU_ARB_MAX_REQ = 8;

    typedef logic [2:0] apu_req_id_t;

endpackage

// File: rtl/cv32e40p_apu_tag_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered APU requests.
module cv32e40p_apu_tag_fifo
    import cv32e40p_apu_core_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  apu_req_id_t      wdata,
    output apu_req_id_t      rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    apu_req_id_t      mem_q [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        full    = (cnt_q == CNT_W'(DEPTH));
        empty   = (cnt_q == '0);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        // Pointers wrap naturally because DEPTH is a power of two.
        wptr_d  = do_push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + PTR_W'(1) : rptr_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        rdata   = mem_q[rptr_q];
        count   = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin sharing of one APU port between NUM_REQ requesters, with
// in-order response routing driven by a tag FIFO of granted requester IDs.
module cv32e40p_apu_arbiter
    import cv32e40p_apu_core_pkg::*;
#(
    parameter  int NUM_REQ          = 2,
    parameter  int APU_NARGS_CPU    = 3,
    parameter  int APU_WOP_CPU      = 6,
    parameter  int APU_NUSFLAGS_CPU = 5,
    parameter  int OUTSTANDING      = 4,
    localparam int CNT_W            = $clog2(OUTSTANDING) + 1
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [NUM_REQ-1:0]                              core_req_i,
    output logic [NUM_REQ-1:0]                              core_gnt_o,
    input  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0]     core_operands_i,
    input  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]             core_op_i,
    output logic [NUM_REQ-1:0]                              core_rvalid_o,
    output logic [31:0]                                     core_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                     core_flags_o,
    output logic                                            apu_req_o,
    input  logic                                            apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]                  apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                          apu_op_o,
    input  logic                                            apu_rvalid_i,
    input  logic [31:0]                                     apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                     apu_flags_i,
    output logic                                            busy_o,
    output logic [CNT_W-1:0]                                outstanding_o,
    output logic                                            resp_err_o
);

    apu_req_id_t ptr_q, ptr_d;
    logic        resp_err_q, resp_err_d;
    apu_req_id_t winner, hi_idx, lo_idx, head;
    logic        hi_found, lo_found, any_req, handshake, resp_valid;
    logic        fifo_full, fifo_empty;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        // Descending scan: the last hit is the lowest index at/after ptr (hi)
        // or, failing that, the lowest index before ptr (wrapped part).
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (core_req_i[i]) begin
                if (i >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = apu_req_id_t'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = apu_req_id_t'(i);
                end
            end
        end
        winner     = hi_found ? hi_idx : lo_idx;
        any_req    = hi_found | lo_found;
        apu_req_o  = any_req & ~fifo_full;
        handshake  = apu_req_o & apu_gnt_i;
        resp_valid = apu_rvalid_i & ~fifo_empty;

        apu_op_o       = '0;
        apu_operands_o = '0;
        core_gnt_o     = '0;
        core_rvalid_o  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (any_req && winner == apu_req_id_t'(i)) begin
                apu_op_o       = core_op_i[i];
                apu_operands_o = core_operands_i[i];
                core_gnt_o[i]  = handshake;
            end
            if (head == apu_req_id_t'(i)) begin
                core_rvalid_o[i] = resp_valid;
            end
        end

        ptr_d = ptr_q;
        if (handshake) begin
            ptr_d = (winner == apu_req_id_t'(NUM_REQ - 1)) ? '0 : winner + 3'd1;
        end
        resp_err_d = resp_err_q | (apu_rvalid_i & fifo_empty);

        core_result_o = apu_result_i;
        core_flags_o  = apu_flags_i;
        busy_o        = ~fifo_empty;
        resp_err_o    = resp_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            resp_err_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            resp_err_q <= resp_err_d;
        end
    end

    cv32e40p_apu_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (handshake),
        .pop   (resp_valid),
        .wdata (winner),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding_o)
    );

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Bench for cv32e40p_apu_arbiter: vector table plus hand sequences, with a
// queue of expected response tags.
module tb_cv32e40p_apu_arbiter;

    localparam int NR = 2;
    localparam int NA = 3;
    localparam int WOP = 6;
    localparam int NF = 5;
    localparam int OUTS = 4;
    localparam int CW = $clog2(OUTS) + 1;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [NR-1:0]                core_req_i;
    logic [NR-1:0]                core_gnt_o;
    logic [NR-1:0][NA-1:0][31:0]  core_operands_i;
    logic [NR-1:0][WOP-1:0]       core_op_i;
    logic [NR-1:0]                core_rvalid_o;
    logic [31:0]                  core_result_o;
    logic [NF-1:0]                core_flags_o;
    logic                         apu_req_o;
    logic                         apu_gnt_i;
    logic [NA-1:0][31:0]          apu_operands_o;
    logic [WOP-1:0]               apu_op_o;
    logic                         apu_rvalid_i;
    logic [31:0]                  apu_result_i;
    logic [NF-1:0]                apu_flags_i;
    logic                         busy_o;
    logic [CW-1:0]                outstanding_o;
    logic                         resp_err_o;

    cv32e40p_apu_arbiter #(
        .NUM_REQ(NR), .APU_NARGS_CPU(NA), .APU_WOP_CPU(WOP),
        .APU_NUSFLAGS_CPU(NF), .OUTSTANDING(OUTS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
        .core_operands_i(core_operands_i), .core_op_i(core_op_i),
        .core_rvalid_o(core_rvalid_o), .core_result_o(core_result_o),
        .core_flags_o(core_flags_o), .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
        .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o),
        .apu_rvalid_i(apu_rvalid_i), .apu_result_i(apu_result_i),
        .apu_flags_i(apu_flags_i), .busy_o(busy_o),
        .outstanding_o(outstanding_o), .resp_err_o(resp_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] res;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
        logic        e_apureq;
        int          src;
        int          e_outst;
        logic        e_err;
    } vec_t;

    vec_t     rows[$];
    int       tag_q[$];
    int       n_tests = 0;
    int       n_fail = 0;
    logic [WOP-1:0] ops [NR];

    function automatic vec_t mk(logic [1:0] req, logic gnt, logic rv, logic [31:0] res,
                                logic [1:0] e_gnt, logic [1:0] e_rv, logic e_apureq,
                                int src, int e_outst, logic e_err);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv; v.res = res;
        v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_apureq = e_apureq;
        v.src = src; v.e_outst = e_outst; v.e_err = e_err;
        return v;
    endfunction

    function automatic logic [31:0] opnd(int r, int a);
        return 32'h1000_0000 * (r + 1) + 32'(a) * 32'h11;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] res);
        core_req_i   = req;
        apu_gnt_i    = gnt;
        apu_rvalid_i = rv;
        apu_result_i = res;
        apu_flags_i  = res[4:0] ^ 5'h15;
    endtask

    // Pops the expected head tag when a response is driven and checks routing.
    task automatic check_resp(input string name, input logic rv);
        logic [1:0] exp_rv;
        exp_rv = 2'b00;
        if (rv && tag_q.size() > 0) begin
            exp_rv = 2'b01 << tag_q.pop_front();
        end
        check({name, " sb_rvalid"}, 32'(core_rvalid_o), 32'(exp_rv));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ops[0] = 6'h11;
        ops[1] = 6'h22;
        for (int r = 0; r < NR; r++) begin
            core_op_i[r] = ops[r];
            for (int a = 0; a < NA; a++) core_operands_i[r][a] = opnd(r, a);
        end
        drive(2'b00, 1'b0, 1'b0, 32'h0);

        //         req    gnt rv  res       e_gnt e_rv  apuq src outst err
        rows.push_back(mk(2'b11, 1, 0, 32'h0, 2'b01, 2'b00, 1, 0, 0, 0));
        rows.push_back(mk(2'b11, 1, 0, 32'h0, 2'b10, 2'b00, 1, 1, 1, 0));
        rows.push_back(mk(2'b11, 1, 0, 32'h0, 2'b01, 2'b00, 1, 0, 2, 0));
        rows.push_back(mk(2'b11, 1, 0, 32'h0, 2'b10, 2'b00, 1, 1, 3, 0));
        rows.push_back(mk(2'b11, 1, 0, 32'h0, 2'b00, 2'b00, 0, 0, 4, 0));
        rows.push_back(mk(2'b11, 1, 1, 32'hA, 2'b00, 2'b01, 0, 0, 4, 0));
        rows.push_back(mk(2'b11, 1, 0, 32'h0, 2'b01, 2'b00, 1, 0, 3, 0));
        rows.push_back(mk(2'b00, 0, 1, 32'h5, 2'b00, 2'b10, 0, 2, 4, 0));
        rows.push_back(mk(2'b00, 0, 1, 32'h6, 2'b00, 2'b01, 0, 2, 3, 0));
        rows.push_back(mk(2'b01, 1, 1, 32'h7, 2'b01, 2'b10, 1, 0, 2, 0));
        rows.push_back(mk(2'b10, 1, 1, 32'h8, 2'b10, 2'b01, 1, 1, 2, 0));
        rows.push_back(mk(2'b00, 0, 1, 32'h9, 2'b00, 2'b01, 0, 2, 2, 0));
        rows.push_back(mk(2'b00, 0, 1, 32'h1F, 2'b00, 2'b10, 0, 2, 1, 0));
        rows.push_back(mk(2'b00, 0, 1, 32'h33, 2'b00, 2'b00, 0, 2, 0, 0));
        rows.push_back(mk(2'b00, 0, 0, 32'h0, 2'b00, 2'b00, 0, 2, 0, 1));
        for (int k = 0; k < 5; k++)
            rows.push_back(mk(2'b11, 0, 0, 32'h0, 2'b00, 2'b00, 1, 0, 0, 1));
        rows.push_back(mk(2'b11, 1, 0, 32'h0, 2'b01, 2'b00, 1, 0, 0, 1));
        rows.push_back(mk(2'b11, 1, 0, 32'h0, 2'b10, 2'b00, 1, 1, 1, 1));

        rst_n = 1'b0;
        #12;
        check("reset outstanding", 32'(outstanding_o), 32'd0);
        check("reset err", 32'(resp_err_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset apu_req", 32'(apu_req_o), 32'd0);
        check("reset gnt", 32'(core_gnt_o), 32'd0);
        check("reset rvalid", 32'(core_rvalid_o), 32'd0);
        check("reset op", 32'(apu_op_o), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < rows.size(); i++) begin
            vec_t v;
            string nm;
            v = rows[i];
            nm = $sformatf("row%0d", i);
            drive(v.req, v.gnt, v.rv, v.res);
            @(negedge clk);
            check({nm, " gnt"}, 32'(core_gnt_o), 32'(v.e_gnt));
            check({nm, " rvalid"}, 32'(core_rvalid_o), 32'(v.e_rv));
            check({nm, " apu_req"}, 32'(apu_req_o), 32'(v.e_apureq));
            check({nm, " op"}, 32'(apu_op_o), (v.src == 2) ? 32'd0 : 32'(ops[v.src]));
            check({nm, " opnd2"}, apu_operands_o[2], (v.src == 2) ? 32'd0 : opnd(v.src, 2));
            check({nm, " outstanding"}, 32'(outstanding_o), 32'(v.e_outst));
            check({nm, " busy"}, 32'(busy_o), 32'(v.e_outst != 0));
            check({nm, " err"}, 32'(resp_err_o), 32'(v.e_err));
            check({nm, " result"}, core_result_o, v.res);
            check({nm, " flags"}, 32'(core_flags_o), 32'(v.res[4:0] ^ 5'h15));
            check_resp(nm, v.rv);
            if (v.e_gnt == 2'b01) tag_q.push_back(0);
            if (v.e_gnt == 2'b10) tag_q.push_back(1);
            next_cycle();
        end

        // Third outstanding grant, then asynchronous reset in the middle of a cycle.
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("pre-reset gnt", 32'(core_gnt_o), 32'b01);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("pre-reset outstanding", 32'(outstanding_o), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outstanding", 32'(outstanding_o), 32'd0);
        check("async reset err", 32'(resp_err_o), 32'd0);
        check("async reset busy", 32'(busy_o), 32'd0);
        tag_q.delete();
        #2 rst_n = 1'b1;
        next_cycle();

        // In-order routing: grant order 1,0,1 then responses A,B,C.
        begin
            logic [1:0] greq [3];
            logic [31:0] rres [3];
            greq[0] = 2'b10; greq[1] = 2'b01; greq[2] = 2'b10;
            rres[0] = 32'hA; rres[1] = 32'hB; rres[2] = 32'hC;
            for (int k = 0; k < 3; k++) begin
                drive(greq[k], 1'b1, 1'b0, 32'h0);
                @(negedge clk);
                check($sformatf("order gnt%0d", k), 32'(core_gnt_o), 32'(greq[k]));
                tag_q.push_back(greq[k] == 2'b10 ? 1 : 0);
                next_cycle();
            end
            for (int k = 0; k < 3; k++) begin
                drive(2'b00, 1'b0, 1'b1, rres[k]);
                @(negedge clk);
                check($sformatf("order busy%0d", k), 32'(busy_o), 32'd1);
                check($sformatf("order result%0d", k), core_result_o, rres[k]);
                check_resp($sformatf("order%0d", k), 1'b1);
                next_cycle();
            end
            drive(2'b00, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            check("order busy after drain", 32'(busy_o), 32'd0);
            check("order outstanding after drain", 32'(outstanding_o), 32'd0);
            next_cycle();
        end

        // A response after reset with nothing outstanding is an error.
        drive(2'b00, 1'b0, 1'b1, 32'hDEAD);
        @(negedge clk);
        check("post-reset spurious rvalid", 32'(core_rvalid_o), 32'd0);
        check("post-reset err before edge", 32'(resp_err_o), 32'd0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("post-reset err set", 32'(resp_err_o), 32'd1);
        next_cycle();
        check("post-reset err held", 32'(resp_err_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cv32e40p_apu_arbiter.md
Name: cv32e40p_apu_arbiter

Overview:
Shares one APU/vector accelerator port between NUM_REQ core-side APU dispatch interfaces, such as several ex-stage instances or an ex-stage plus a DMA/vector sequencer.
It arbitrates request/grant round-robin, forwards the winner's op and operands, and records the winner ID in an in-order tag FIFO.
Responses (rvalid/result/flags) are routed back to the requester at the FIFO head.
The accelerator returns responses strictly in grant order.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
APU_NARGS_CPU, 3, operands per request
APU_WOP_CPU, 6, op-code width
APU_NUSFLAGS_CPU, 5, response flag width
OUTSTANDING, 4, tag FIFO depth: max granted-but-unanswered requests (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
core_req_i  in  NUM_REQ  per-requester request
core_gnt_o  out  NUM_REQ  per-requester grant (one-hot or zero)
core_operands_i  in  NUM_REQ x APU_NARGS_CPU x 32  operands
core_op_i  in  NUM_REQ x APU_WOP_CPU  op-codes
core_rvalid_o  out  NUM_REQ  per-requester response valid (one-hot or zero)
core_result_o  out  32  result, broadcast to all requesters
core_flags_o  out  APU_NUSFLAGS_CPU  response flags, broadcast to all requesters
apu_req_o  out  1  accelerator request
apu_gnt_i  in  1  accelerator grant
apu_operands_o  out  APU_NARGS_CPU x 32  winner operands
apu_op_o  out  APU_WOP_CPU  winner op
apu_rvalid_i  in  1  accelerator response valid
apu_result_i  in  32  accelerator result
apu_flags_i  in  APU_NUSFLAGS_CPU  accelerator flags
busy_o  out  1  one or more responses outstanding
outstanding_o  out  clog2(OUTSTANDING)+1  number of entries in the tag FIFO
resp_err_o  out  1  sticky: a response arrived with no request outstanding

Behaviour:
- Reset (async, rst_n=0):
  - RR pointer = 0.
  - Tag FIFO empty: read/write pointers 0, count 0.
  - resp_err_o = 0.
  - Combinational outputs follow the inputs; with all core_req_i=0, every request/grant/rvalid output is 0.
- Requester contract: core_req_i[i] stays high with stable op/operands until core_gnt_o[i]; it may deassert only after grant.
- Arbitration (combinational, 0 cycles):
  - Winner = first set core_req_i index scanning ptr, ptr+1, ..., wrapping mod NUM_REQ.
- Request forwarding:
  - apu_req_o = |core_req_i & ~fifo_full.
  - apu_op_o/apu_operands_o = winner's inputs; all zeros when no request.
  - When the FIFO is full, apu_req_o=0 even if a pop occurs in the same cycle (no bypass).
- Grant:
  - Handshake = apu_req_o & apu_gnt_i.
  - core_gnt_o[winner] = handshake; all other grants 0.
- On handshake (registered):
  - Push winner index into the FIFO.
  - ptr <= (winner+1) mod NUM_REQ.
  - No handshake: ptr unchanged, even if requests are pending and stalled.
- Response (combinational, 0 cycles): when apu_rvalid_i & ~fifo_empty:
  - core_rvalid_o[head] = 1.
  - Pop the FIFO at the clock edge.
- Result/flags passthrough: core_result_o = apu_result_i and core_flags_o = apu_flags_i, unconditionally.
- Push and pop in the same cycle:
  - Count unchanged.
  - The pop uses the old head; the pushed entry lands at the tail.
  - Pushing into a FIFO that becomes empty in the same cycle is legal.
- Response with empty FIFO:
  - core_rvalid_o = 0; the response is dropped.
  - resp_err_o <= 1 and stays set until reset.
- Status: busy_o = ~fifo_empty; outstanding_o = count (0..OUTSTANDING).
- Reset mid-operation: all outstanding tags are discarded; later responses from the accelerator set resp_err_o.
- Pointers wrap mod OUTSTANDING. Full: count == OUTSTANDING. Empty: count == 0.

Decomposition:
- cv32e40p_apu_core_pkg additions:
  - APU_ARB_MAX_REQ = 8
  - typedef apu_req_id_t (logic [2:0])
- One sub-module, cv32e40p_apu_tag_fifo:
  - Holds OUTSTANDING entries of apu_req_id_t.
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Asynchronous active-low reset on the same clk/rst_n.
- The arbiter top holds the RR pointer, winner scan, muxes, response routing and the error flag.

Test Plan:
- Round-robin: NUM_REQ=2, both req high, apu_gnt_i=1 every cycle -> core_gnt_o sequence 01,10,01,10; FIFO tags 0,1,0,1; apu_op_o matches the granted requester's op each cycle.
- Stall fairness: req0 and req1 high, apu_gnt_i=0 for 5 cycles, then 1 -> no core grant while gnt low; ptr stays 0; first grant goes to req0, next to req1.
- Full: 4 grants with no rvalid -> outstanding_o=4, apu_req_o=0 despite req high. Then one rvalid -> core_rvalid_o=01 (head tag 0), apu_req_o=1 the next cycle.
- In-order routing: grant order 1,0,1; responses with results 0xA,0xB,0xC -> core_rvalid_o = 10,01,10 with core_result_o=0xA,0xB,0xC; busy_o falls after the third response.
- Simultaneous push/pop: outstanding=2, handshake and rvalid in the same cycle -> outstanding stays 2, the popped tag is the old head, the new tag is at the tail.
- Spurious response: empty FIFO, apu_rvalid_i=1 -> core_rvalid_o=0, resp_err_o=1 from the next cycle, held. Then rst_n=0 mid-traffic with outstanding=3 -> outstanding_o=0 and resp_err_o=0 immediately (asynchronously).
